// File: rtl/sram_arbiter.sv
// Two-port arbiter for the board SRAM: recorder writes, DSP reads, round-robin on ties.
// Every access is a fixed ACC_CYC strobe window followed by one TURN cycle that carries the ack.
module sram_arbiter #(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 16,
  parameter int ACC_CYC = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rec_req,
  input  logic [ADDR_W-1:0] i_rec_addr,
  input  logic [DATA_W-1:0] i_rec_data,
  output logic              o_rec_ack,
  input  logic              i_dsp_req,
  input  logic [ADDR_W-1:0] i_dsp_addr,
  output logic [DATA_W-1:0] o_dsp_data,
  output logic              o_dsp_ack,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_sram_dq,
  output logic              o_sram_dq_oe,
  input  logic [DATA_W-1:0] i_sram_dq,
  output logic              o_sram_ce_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_we_n,
  output logic              o_sram_lb_n,
  output logic              o_sram_ub_n,
  output logic              o_busy
);

  typedef enum logic [1:0] {IDLE, WR, RD, TURN} state_t;

  state_t     state, state_nx;
  logic [3:0] cnt;
  logic       last_dsp;
  logic       grant_rec, grant_dsp;
  logic       ce_nx, oe_nx, we_nx, dq_oe_nx, rec_ack_nx, dsp_ack_nx, busy_nx;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      cnt      <= '0;
      last_dsp <= 1'b1;
    end else begin
      state <= state_nx;
      if (grant_rec || grant_dsp)
        cnt <= 4'(ACC_CYC - 1);
      else if ((state == WR || state == RD) && cnt != 4'd0)
        cnt <= cnt - 4'd1;
      if (grant_rec) last_dsp <= 1'b0;
      if (grant_dsp) last_dsp <= 1'b1;
    end
  end

  always_comb begin
    state_nx  = state;
    grant_rec = 1'b0;
    grant_dsp = 1'b0;
    case (state)
      IDLE: begin
        if (i_rec_req && (!i_dsp_req || last_dsp)) begin
          grant_rec = 1'b1;
          state_nx  = WR;
        end else if (i_dsp_req) begin
          grant_dsp = 1'b1;
          state_nx  = RD;
        end
      end
      WR:      if (cnt == 4'd0) state_nx = TURN;
      RD:      if (cnt == 4'd0) state_nx = TURN;
      TURN:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output values are derived from the next state so the registered pins line up with the state.
  // dq_oe stays on through TURN after a write so the data is held past the rising we_n.
  always_comb begin
    ce_nx      = !(state_nx == WR || state_nx == RD);
    we_nx      = state_nx != WR;
    oe_nx      = state_nx != RD;
    dq_oe_nx   = (state_nx == WR) || (state_nx == TURN && state == WR);
    rec_ack_nx = (state == WR) && (state_nx == TURN);
    dsp_ack_nx = (state == RD) && (state_nx == TURN);
    busy_nx    = state_nx != IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_sram_ce_n  <= 1'b1;
      o_sram_oe_n  <= 1'b1;
      o_sram_we_n  <= 1'b1;
      o_sram_lb_n  <= 1'b1;
      o_sram_ub_n  <= 1'b1;
      o_sram_dq_oe <= 1'b0;
      o_rec_ack    <= 1'b0;
      o_dsp_ack    <= 1'b0;
      o_busy       <= 1'b0;
      o_sram_addr  <= '0;
      o_sram_dq    <= '0;
      o_dsp_data   <= '0;
    end else begin
      o_sram_ce_n  <= ce_nx;
      o_sram_oe_n  <= oe_nx;
      o_sram_we_n  <= we_nx;
      o_sram_lb_n  <= ce_nx;
      o_sram_ub_n  <= ce_nx;
      o_sram_dq_oe <= dq_oe_nx;
      o_rec_ack    <= rec_ack_nx;
      o_dsp_ack    <= dsp_ack_nx;
      o_busy       <= busy_nx;
      if (grant_rec) begin
        o_sram_addr <= i_rec_addr;
        o_sram_dq   <= i_rec_data;
      end else if (grant_dsp) begin
        o_sram_addr <= i_dsp_addr;
      end
      if (state == RD && cnt == 4'd0) o_dsp_data <= i_sram_dq;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench: ACC_CYC=2 instance for timing/arbitration/reset, ACC_CYC=1 instance for a 100-op run.
module tb_sram_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ACC_CYC = 2 instance
  logic        rec_req, rec_ack, dsp_req, dsp_ack;
  logic [19:0] rec_addr, dsp_addr, s_addr;
  logic [15:0] rec_data, dsp_data, s_dq, s_dqi;
  logic        s_oe, ce_n, oe_n, we_n, lb_n, ub_n, busy;

  sram_arbiter #(.ADDR_W(20), .DATA_W(16), .ACC_CYC(2)) u_dut (
    .i_clk(clk), .i_rst(rst),
    .i_rec_req(rec_req), .i_rec_addr(rec_addr), .i_rec_data(rec_data), .o_rec_ack(rec_ack),
    .i_dsp_req(dsp_req), .i_dsp_addr(dsp_addr), .o_dsp_data(dsp_data), .o_dsp_ack(dsp_ack),
    .o_sram_addr(s_addr), .o_sram_dq(s_dq), .o_sram_dq_oe(s_oe), .i_sram_dq(s_dqi),
    .o_sram_ce_n(ce_n), .o_sram_oe_n(oe_n), .o_sram_we_n(we_n),
    .o_sram_lb_n(lb_n), .o_sram_ub_n(ub_n), .o_busy(busy)
  );

  // ACC_CYC = 1 instance
  logic        rec_req1, rec_ack1, dsp_req1, dsp_ack1;
  logic [19:0] rec_addr1, dsp_addr1, s_addr1;
  logic [15:0] rec_data1, dsp_data1, s_dq1, s_dqi1;
  logic        s_oe1, ce_n1, oe_n1, we_n1, lb_n1, ub_n1, busy1;

  sram_arbiter #(.ADDR_W(20), .DATA_W(16), .ACC_CYC(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst),
    .i_rec_req(rec_req1), .i_rec_addr(rec_addr1), .i_rec_data(rec_data1), .o_rec_ack(rec_ack1),
    .i_dsp_req(dsp_req1), .i_dsp_addr(dsp_addr1), .o_dsp_data(dsp_data1), .o_dsp_ack(dsp_ack1),
    .o_sram_addr(s_addr1), .o_sram_dq(s_dq1), .o_sram_dq_oe(s_oe1), .i_sram_dq(s_dqi1),
    .o_sram_ce_n(ce_n1), .o_sram_oe_n(oe_n1), .o_sram_we_n(we_n1),
    .o_sram_lb_n(lb_n1), .o_sram_ub_n(ub_n1), .o_busy(busy1)
  );

  // SRAM models: asynchronous read while ce/oe low, write on each clock with ce/we low
  logic [15:0] mem0 [0:1048575];
  logic [15:0] mem1 [0:1048575];
  logic [15:0] ref_mem [int];

  function automatic logic [15:0] pat(input logic [19:0] a);
    return a[15:0] ^ 16'hA5A5;
  endfunction

  assign s_dqi  = (!ce_n  && !oe_n)  ? mem0[s_addr]  : 16'h0;
  assign s_dqi1 = (!ce_n1 && !oe_n1) ? mem1[s_addr1] : 16'h0;

  always @(posedge clk) begin
    if (!ce_n  && !we_n  && !lb_n  && !ub_n)  mem0[s_addr]  <= s_dq;
    if (!ce_n1 && !we_n1 && !lb_n1 && !ub_n1) mem1[s_addr1] <= s_dq1;
  end

  // Bus-contention monitor over the whole run
  int viol = 0;
  always @(negedge clk) begin
    if (!oe_n && s_oe)    viol++;
    if (!oe_n && !we_n)   viol++;
    if (!oe_n1 && s_oe1)  viol++;
    if (!oe_n1 && !we_n1) viol++;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [19:0] a, last_wr;
    logic [15:0] d, exp_d;
    int n, acks;
    bit have_wr;

    for (int i = 0; i < 1048576; i++) begin
      mem0[i] = 16'h0;
      mem1[i] = pat(20'(i));
    end
    mem0[20'hFFFFF] = 16'h1234;
    rec_req = 0; rec_addr = '0; rec_data = '0; dsp_req = 0; dsp_addr = '0;
    rec_req1 = 0; rec_addr1 = '0; rec_data1 = '0; dsp_req1 = 0; dsp_addr1 = '0;

    // reset state
    tick(); tick();
    chk("rst_ce_n", ce_n, 1); chk("rst_oe_n", oe_n, 1); chk("rst_we_n", we_n, 1);
    chk("rst_lb_ub", {lb_n, ub_n}, 2'b11); chk("rst_dq_oe", s_oe, 0);
    chk("rst_acks", {rec_ack, dsp_ack}, 0); chk("rst_busy", busy, 0);
    chk("rst_addr", s_addr, 0); chk("rst_dq", s_dq, 0); chk("rst_dsp_data", dsp_data, 0);
    rst = 0;
    tick();

    // single write
    rec_req = 1; rec_addr = 20'h00010; rec_data = 16'hBEEF;
    tick();
    chk("wr_t1_we", we_n, 0); chk("wr_t1_ce", ce_n, 0); chk("wr_t1_oe", oe_n, 1);
    chk("wr_t1_dq_oe", s_oe, 1); chk("wr_t1_busy", busy, 1); chk("wr_t1_ack", rec_ack, 0);
    chk("wr_addr", s_addr, 20'h00010); chk("wr_dq", s_dq, 16'hBEEF);
    rec_addr = 20'h00777; rec_data = 16'h0000;   // changes after grant are ignored
    tick();
    chk("wr_t2_we", we_n, 0); chk("wr_t2_ack", rec_ack, 0); chk("wr_t2_addr", s_addr, 20'h00010);
    tick();
    chk("wr_t3_ack", rec_ack, 1); chk("wr_t3_we", we_n, 1); chk("wr_t3_ce", ce_n, 1);
    chk("wr_t3_dq_oe", s_oe, 1); chk("wr_t3_dq", s_dq, 16'hBEEF);
    rec_req = 0;
    tick();
    chk("wr_t4_ack", rec_ack, 0); chk("wr_t4_dq_oe", s_oe, 0); chk("wr_t4_busy", busy, 0);
    chk("wr_mem", mem0[20'h00010], 16'hBEEF);

    // single read at top of address range
    dsp_req = 1; dsp_addr = 20'hFFFFF;
    tick();
    chk("rd_t1_oe", oe_n, 0); chk("rd_t1_we", we_n, 1); chk("rd_t1_dq_oe", s_oe, 0);
    chk("rd_t1_addr", s_addr, 20'hFFFFF);
    tick();
    chk("rd_t2_oe", oe_n, 0); chk("rd_t2_ack", dsp_ack, 0);
    tick();
    chk("rd_t3_ack", dsp_ack, 1); chk("rd_t3_data", dsp_data, 16'h1234); chk("rd_t3_oe", oe_n, 1);
    dsp_req = 0;
    tick();
    chk("rd_t4_ack", dsp_ack, 0); chk("rd_t4_hold", dsp_data, 16'h1234);
    tick();
    chk("rd_t5_hold", dsp_data, 16'h1234);

    // simultaneous held requests after reset: REC, DSP, REC, DSP
    rst = 1; tick(); rst = 0;
    chk("tie_rst_data", dsp_data, 0);
    rec_req = 1; rec_addr = 20'h00020; rec_data = 16'h5555;
    dsp_req = 1; dsp_addr = 20'h00010;
    for (int k = 1; k <= 15; k++) begin
      tick();
      chk($sformatf("tie_rec_ack_%0d", k), rec_ack, (k == 3 || k == 11) ? 1 : 0);
      chk($sformatf("tie_dsp_ack_%0d", k), dsp_ack, (k == 7 || k == 15) ? 1 : 0);
      if (k == 7) chk("tie_rd_data", dsp_data, 16'hBEEF);
      if (k == 1) chk("tie_first_we", we_n, 0);
      if (k == 5) chk("tie_second_oe", oe_n, 0);
    end
    rec_req = 0; dsp_req = 0;
    tick();
    chk("tie_idle", busy, 0);
    chk("tie_mem", mem0[20'h00020], 16'h5555);

    // write directly followed by read: bus turnaround
    rec_req = 1; rec_addr = 20'h00030; rec_data = 16'h0F0F;
    tick(); tick(); tick();
    chk("ta_ack", rec_ack, 1); chk("ta_turn_dq_oe", s_oe, 1); chk("ta_turn_oe", oe_n, 1);
    rec_req = 0; dsp_req = 1; dsp_addr = 20'h00030;
    tick();
    chk("ta_idle_dq_oe", s_oe, 0); chk("ta_idle_oe", oe_n, 1);
    tick();
    chk("ta_rd_oe", oe_n, 0); chk("ta_rd_dq_oe", s_oe, 0);
    tick(); tick();
    chk("ta_rd_ack", dsp_ack, 1); chk("ta_rd_data", dsp_data, 16'h0F0F);
    dsp_req = 0;
    tick();

    // reset during the first WR cycle
    rec_req = 1; rec_addr = 20'h00040; rec_data = 16'hCAFE;
    tick();
    chk("mr_wr", we_n, 0);
    rst = 1;
    tick();
    chk("mr_we", we_n, 1); chk("mr_ce", ce_n, 1); chk("mr_dq_oe", s_oe, 0);
    chk("mr_busy", busy, 0); chk("mr_ack", rec_ack, 0); chk("mr_data", dsp_data, 0);
    rst = 0; rec_req = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("mr_no_ack", rec_ack, 0);
    end

    // ACC_CYC = 1: alternating reads and writes
    acks = 0; have_wr = 0; last_wr = '0;
    for (int i = 0; i < 100; i++) begin
      if (i % 2 == 1) begin
        a = 20'($urandom); d = 16'($urandom);
        ref_mem[int'(a)] = d; last_wr = a; have_wr = 1;
        rec_req1 = 1; rec_addr1 = a; rec_data1 = d;
        n = 0;
        do begin tick(); n++; end while (!rec_ack1 && n < 10);
        chk($sformatf("a1_wr_lat_%0d", i), n, 2);
        if (rec_ack1) acks++;
        rec_req1 = 0;
      end else begin
        a = (i % 4 == 0 && have_wr) ? last_wr : 20'($urandom);
        exp_d = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : pat(a);
        dsp_req1 = 1; dsp_addr1 = a;
        n = 0;
        do begin tick(); n++; end while (!dsp_ack1 && n < 10);
        chk($sformatf("a1_rd_lat_%0d", i), n, 2);
        chk($sformatf("a1_rd_data_%0d", i), dsp_data1, exp_d);
        if (dsp_ack1) acks++;
        dsp_req1 = 0;
      end
      tick();
    end
    chk("a1_ack_count", acks, 100);
    chk("a1_idle", busy1, 0);
    chk("no_overlap", viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
